// File: rtl/deser_arb_pkg.sv
// Shared types for the round-robin deserializer arbiter: FSM state encoding and byte width.
package deser_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    XFER     = 2'd1,
    WAIT_RDY = 2'd2,
    ACK      = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping past N-1 to 0.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [PTR_W-1:0] pick_idx,
  output logic             any
);

  localparam int SUM_W = PTR_W + 1;

  logic [2*N-1:0]   dbl_req;
  logic [2*N-1:0]   dbl_pick;
  logic [N-1:0]     rot;
  logic [N-1:0]     rot_pick;
  logic [PTR_W-1:0] off;
  logic [SUM_W-1:0] sum;

  // Rotate so bit 0 is the pointer position; the lowest set bit then wins.
  assign dbl_req = {req, req} >> ptr;
  assign rot     = dbl_req[N-1:0];

  always_comb begin
    rot_pick = '0;
    off      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        rot_pick    = '0;
        rot_pick[k] = 1'b1;
        off         = PTR_W'(k);
      end
    end
  end

  assign dbl_pick = {{N{1'b0}}, rot_pick} << ptr;
  assign pick     = dbl_pick[N-1:0] | dbl_pick[2*N-1:N];

  assign sum      = {1'b0, ptr} + {1'b0, off};
  assign pick_idx = (sum >= SUM_W'(N)) ? PTR_W'(sum - SUM_W'(N)) : PTR_W'(sum);
  assign any      = |req;

endmodule

// File: rtl/deser_rr_arbiter.sv
// Shares one serial deserializer among N_SRC serial sources, one byte per grant, round-robin,
// and holds each finished byte with its source id in a one-entry output register.
module deser_rr_arbiter
  import deser_arb_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int SRC_W   = $clog2(N_SRC),
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  src_req,
  input  logic [N_SRC-1:0]  src_bit,
  input  logic [N_SRC-1:0]  src_bit_valid,
  output logic [N_SRC-1:0]  src_grant,
  output logic              deser_data_in,
  output logic              deser_write_in,
  output logic              deser_ack_in,
  input  logic [BYTE_W-1:0] deser_data_out,
  input  logic              deser_data_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic [SRC_W-1:0]  out_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_stall,
  input  logic              err_clr
);

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam int CNT_W = $clog2(BYTE_W);

  state_t             state;
  logic [N_SRC-1:0]   pick;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;
  logic [SRC_W-1:0]   grant_id;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   next_ptr;
  logic [CNT_W-1:0]   bit_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               lane_bit;
  logic               lane_valid;
  logic               in_xfer;
  logic               last_bit;
  logic               tmo_hit;
  logic               can_capture;
  logic               out_take;
  logic               stall_set;

  rr_pick #(
    .N     (N_SRC),
    .PTR_W (SRC_W)
  ) u_rr_pick (
    .req      (src_req),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign lane_bit   = src_bit[grant_id];
  assign lane_valid = src_bit_valid[grant_id];
  assign in_xfer    = (state == XFER);

  assign deser_data_in  = in_xfer & lane_bit;
  assign deser_write_in = in_xfer & lane_valid;
  assign deser_ack_in   = (state == ACK);
  assign busy           = (state != IDLE);

  assign next_ptr    = (grant_id == SRC_W'(N_SRC - 1)) ? '0 : grant_id + 1'b1;
  assign last_bit    = lane_valid && (bit_cnt == CNT_W'(BYTE_W - 1));
  assign tmo_hit     = !lane_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign stall_set   = in_xfer && tmo_hit && (bit_cnt != '0);

  // Output handshake: a word moves on any edge where out_valid & out_ready; out_valid
  // never drops without a transfer, and a new capture only happens once the slot is
  // empty or emptying on that same edge.
  assign out_take    = out_valid && out_ready;
  assign can_capture = (state == WAIT_RDY) && deser_data_ready && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      src_grant <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            src_grant <= pick;
            grant_id  <= pick_idx;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (lane_valid) begin
            tmo_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
              src_grant <= '0;
              state     <= WAIT_RDY;
            end
          end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end else if (bit_cnt == '0) begin
            // Nothing reached the deserializer yet, so the grant can be withdrawn cleanly.
            src_grant <= '0;
            rr_ptr    <= next_ptr;
            state     <= IDLE;
          end
        end
        WAIT_RDY: begin
          if (can_capture) state <= ACK;
        end
        ACK: begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_stall <= 1'b0;
    end else if (stall_set) begin
      err_stall <= 1'b1;
    end else if (err_clr) begin
      err_stall <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
    end else if (can_capture) begin
      out_data  <= deser_data_out;
      out_src   <= grant_id;
      out_valid <= 1'b1;
    end else if (out_take) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deser_rr_arbiter.sv
// Bench for deser_rr_arbiter with a behavioural 8-bit deserializer and a round-robin order model.
module tb_deser_rr_arbiter;
  import deser_arb_pkg::*;

  localparam int N       = 4;
  localparam int SRC_W   = 2;
  localparam int TIMEOUT = 16;
  localparam int W       = SRC_W + 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     src_req, src_bit, src_bit_valid, src_grant;
  logic             deser_data_in, deser_write_in, deser_ack_in;
  logic [7:0]       deser_data_out;
  logic             deser_data_ready;
  logic [7:0]       out_data;
  logic [SRC_W-1:0] out_src;
  logic             out_valid, out_ready, busy, err_stall, err_clr;

  logic [7:0]       src_q[N][$];
  int               bit_idx[N];
  int               stop_at[N];
  int               idle_run[N];
  logic [W-1:0]     exp_q[$];
  int               ack_cyc[$];
  int               model_ptr, gap_pct, rdy_mode, cyc, checks, errors;
  bit               noise, prev_ack;

  logic [7:0]       d_sh;
  logic [2:0]       d_cnt;

  always #5 clk = ~clk;

  deser_rr_arbiter #(.N_SRC(N), .SRC_W(SRC_W), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .src_req          (src_req),
    .src_bit          (src_bit),
    .src_bit_valid    (src_bit_valid),
    .src_grant        (src_grant),
    .deser_data_in    (deser_data_in),
    .deser_write_in   (deser_write_in),
    .deser_ack_in     (deser_ack_in),
    .deser_data_out   (deser_data_out),
    .deser_data_ready (deser_data_ready),
    .out_data         (out_data),
    .out_src          (out_src),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .err_stall        (err_stall),
    .err_clr          (err_clr)
  );

  // Deserializer: LSB-first shift, data_ready rises on the edge taking the 8th bit, cleared by ack.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      d_sh <= '0; d_cnt <= '0; deser_data_out <= '0; deser_data_ready <= 1'b0;
    end else if (deser_ack_in) begin
      deser_data_ready <= 1'b0; d_cnt <= '0;
    end else if (deser_write_in) begin
      d_sh <= {deser_data_in, d_sh[7:1]};
      d_cnt <= d_cnt + 3'd1;
      if (d_cnt == 3'd7) begin
        deser_data_out <= {deser_data_in, d_sh[7:1]};
        deser_data_ready <= 1'b1;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin order derived from queued bytes: visit sources from the pointer, one byte each.
  task automatic model_expect();
    int cnt[N];
    int pos[N];
    int left;
    left = 0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = src_q[i].size(); pos[i] = 0; left += cnt[i];
    end
    while (left > 0) begin
      for (int k = 0; k < N; k++) begin
        int s;
        logic [7:0] b;
        s = (model_ptr + k) % N;
        if (cnt[s] > 0) begin
          b = src_q[s][pos[s]];
          exp_q.push_back({SRC_W'(s), b});
          pos[s]++; cnt[s]--; left--;
          model_ptr = (s + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grant"}, src_grant, 0);
    check({tag, "_data_in"}, deser_data_in, 0);
    check({tag, "_write_in"}, deser_write_in, 0);
    check({tag, "_ack_in"}, deser_ack_in, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_src"}, out_src, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_err_stall"}, err_stall, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    src_req = '0; src_bit = '0; src_bit_valid = '0; out_ready = 1'b0; err_clr = 1'b0;
    #1;
    check_reset_vals(tag);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_ptr = 0; prev_ack = 1'b0;
    for (int i = 0; i < N; i++) begin
      bit_idx[i] = 0; idle_run[i] = 0;
    end
  endtask

  // One cycle: drive lanes at the falling edge, then check forwarding, ack and output transfer.
  task automatic step();
    logic exp_w, exp_d;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      logic [7:0] cur;
      src_bit_valid[i] = 1'b0;
      src_bit[i] = 1'($urandom_range(0, 1));
      src_req[i] = (src_q[i].size() > 0);
      if (src_grant[i]) begin
        if (noise && $urandom_range(0, 3) == 0) src_req[i] = 1'b0;
        if (src_q[i].size() > 0 && bit_idx[i] < stop_at[i] &&
            (idle_run[i] >= 8 || $urandom_range(0, 99) >= gap_pct)) begin
          cur = src_q[i][0];
          src_bit[i] = cur[bit_idx[i]];
          src_bit_valid[i] = 1'b1;
          bit_idx[i]++; idle_run[i] = 0;
          if (bit_idx[i] == 8) begin
            void'(src_q[i].pop_front());
            bit_idx[i] = 0;
          end
        end else begin
          idle_run[i]++;
        end
      end else if (noise) begin
        src_bit_valid[i] = 1'($urandom_range(0, 1));
      end
    end
    out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    #1;
    exp_w = |(src_grant & src_bit_valid);
    exp_d = |(src_grant & src_bit);
    check("grant_onehot0", $onehot0(src_grant), 1);
    check("write_in", deser_write_in, exp_w);
    if (exp_w) check("data_in", deser_data_in, exp_d);
    if (prev_ack) check("ready_after_ack", deser_data_ready, 0);
    if (deser_ack_in) begin
      check("ack_single", prev_ack, 0);
      ack_cyc.push_back(cyc);
    end
    prev_ack = deser_ack_in;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", {out_src, out_data}, 0);
      else check("out_word", {out_src, out_data}, exp_q.pop_front());
    end
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic run_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || busy || pending()) && n < budget) begin
      step(); n++;
    end
    check({tag, "_in_budget"}, (n < budget), 1);
  endtask

  initial begin
    int n, t0;
    checks = 0; errors = 0; cyc = 0; model_ptr = 0;
    gap_pct = 0; rdy_mode = 1; noise = 1'b0; prev_ack = 1'b0;
    for (int i = 0; i < N; i++) stop_at[i] = 8;
    do_reset("rst");

    // Single byte from source 1, one bit per cycle.
    src_q[1].push_back(8'hA5);
    model_expect();
    ack_cyc.delete();
    t0 = cyc + 1;
    run_done("t1", 60);
    check("t1_acks", ack_cyc.size(), 1);
    check("t1_latency", (ack_cyc.size() > 0) ? ack_cyc[0] - t0 : -1, 10);
    check("t1_out_data", out_data, 8'hA5);
    check("t1_out_src", out_src, 1);
    check("t1_out_valid", out_valid, 0);

    // Three continuous requesters from a fresh pointer: order 0,2,3,0,2,3 at 11 cycles per byte.
    do_reset("t2_rst");
    src_q[0] = '{8'h11, 8'h11};
    src_q[2] = '{8'h22, 8'h22};
    src_q[3] = '{8'h33, 8'h33};
    model_expect();
    ack_cyc.delete();
    run_done("t2", 200);
    check("t2_acks", ack_cyc.size(), 6);
    for (int k = 1; k < 6; k++)
      if (k < ack_cyc.size()) check("t2_spacing", ack_cyc[k] - ack_cyc[k-1], 11);

    // Consumer stalls: second byte waits in WAIT_RDY while the first is held.
    src_q[0] = '{8'h5A, 8'hC3};
    model_expect();
    rdy_mode = 0;
    n = 0;
    while (src_q[0].size() > 0 && n < 100) begin step(); n++; end
    check("t3_bits_in_budget", (n < 100), 1);
    repeat (5) step();
    check("t3_state", dut.state, WAIT_RDY);
    check("t3_ack_low", deser_ack_in, 0);
    check("t3_held_data", out_data, 8'h5A);
    check("t3_held_src", out_src, 0);
    check("t3_held_valid", out_valid, 1);
    rdy_mode = 1;
    step();
    step();
    check("t3_second_data", out_data, 8'hC3);
    check("t3_second_valid", out_valid, 1);
    check("t3_ack_now", deser_ack_in, 1);
    run_done("t3", 50);

    // Granted source 2 stays silent: grant withdrawn after TIMEOUT idle cycles, source 3 next.
    src_q[2] = '{8'h77};
    src_q[3] = '{8'h44};
    stop_at[2] = 0;
    exp_q.push_back({SRC_W'(3), 8'h44});
    model_ptr = 0;
    n = 0;
    while (!src_grant[2] && n < 20) begin step(); n++; end
    check("t4_grant2", src_grant, 4'b0100);
    repeat (TIMEOUT - 1) step();
    check("t4_hold", src_grant, 4'b0100);
    step();
    check("t4_drop", src_grant, 0);
    check("t4_idle", busy, 0);
    src_q[2].delete();
    stop_at[2] = 8;
    step();
    check("t4_next_grant", src_grant, 4'b1000);
    run_done("t4", 60);

    // Source 0 stalls after 3 bits: sticky error, byte still completes, then cleared.
    src_q[0] = '{8'h96};
    stop_at[0] = 3;
    model_expect();
    n = 0;
    while (bit_idx[0] < 3 && n < 30) begin step(); n++; end
    check("t5_three_bits", bit_idx[0], 3);
    repeat (TIMEOUT) step();
    check("t5_no_err_yet", err_stall, 0);
    step();
    check("t5_err_set", err_stall, 1);
    check("t5_still_xfer", dut.state, XFER);
    check("t5_still_granted", src_grant, 4'b0001);
    repeat (3) step();
    check("t5_err_kept", err_stall, 1);
    stop_at[0] = 8;
    run_done("t5", 60);
    check("t5_err_sticky", err_stall, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_err_cleared", err_stall, 0);

    // Reset after 4 bits discards the partial byte; the full byte then arrives intact.
    src_q[1] = '{8'h3C};
    model_expect();
    n = 0;
    while (bit_idx[1] < 4 && n < 30) begin step(); n++; end
    @(posedge clk);
    #1;
    exp_q.delete();
    do_reset("t6_rst");
    model_expect();
    run_done("t6", 60);

    // Random traffic: random byte counts, bit gaps, consumer backpressure and lane noise.
    gap_pct = 30; rdy_mode = 2; noise = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = $urandom_range(0, 3);
        for (int j = 0; j < c; j++) src_q[i].push_back(8'($urandom_range(0, 255)));
      end
      model_expect();
      run_done("rand", 600);
    end
    rdy_mode = 1;
    repeat (3) step();
    check("final_exp_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
